lcg_stim_gen: RTL and testbench
===============================

Name: lcg_stim_gen

Overview:
- Synthesizable, parametrised stimulus source for the fuzz-rewiring flow.
- Produces a deterministic pseudo-random vector stream with a 32-bit LCG: state = state*0x41C64E6D + 0x3039, mod 2^32.
- Each vector is assembled from consecutive 32-bit LCG words, LSW first. The top partial word takes the low bits of its LCG step.
- Feeds a DUT's flat input bus over a valid/ready handshake, with vector counting, a done flag and seed reload.

Parameters:
- OUT_W, 141: output vector width in bits, 1..1024. WORDS = ceil(OUT_W/32); REM = OUT_W - 32*(WORDS-1).
- SEED, 32'hF30AC820: LCG state loaded at reset.
- CNT_W, 16: width of the vector-count request and the counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seed_load  in  1  load seed_in into the LCG state.
- seed_in  in  32  new seed value.
- start  in  1  one-cycle request to begin a run.
- num_vec  in  CNT_W  vectors to emit in the run; 0 means free-run.
- stop  in  1  abort the current run.
- out_valid  out  1  out_vec holds a vector.
- out_ready  in  1  consumer accepts out_vec.
- out_vec  out  OUT_W  current vector.
- busy  out  1  high in FILL or PRESENT.
- done  out  1  run complete; sticky until the next start.
- vec_count  out  CNT_W  vectors accepted in the current run; wraps in free-run.

Behaviour:
- Reset: state=SEED; FSM=IDLE; out_vec=0, out_valid=0, busy=0, done=0, vec_count=0; shadow buffer cleared.
- FSM states: IDLE, FILL, PRESENT, DONE.
- IDLE/DONE:
  - seed_load=1 -> state<=seed_in.
  - start=1 -> latch num_vec, clear vec_count and done, go to FILL.
  - start and seed_load in the same cycle: the seed loads first, so the run uses seed_in.
- FILL:
  - One LCG step per cycle. The stepped value is written to shadow word w, w=0..WORDS-1.
  - Last word uses step[REM-1:0].
  - After WORDS cycles: out_vec<=shadow, out_valid<=1, go to PRESENT.
  - Latency: start in cycle T -> out_valid high at T+WORDS+1.
- PRESENT:
  - While out_valid=1, out_vec is stable until out_ready=1.
  - The shadow refills concurrently. The refill begins the cycle after the out_vec load and takes WORDS cycles, then holds until consumed.
  - On handshake (out_valid & out_ready):
    - vec_count increments.
    - If vec_count+1 == latched num_vec (num_vec!=0): out_valid<=0, go to DONE, done<=1.
    - Else if the shadow is full: out_vec<=shadow the next cycle, out_valid stays 1, refill restarts.
    - Else: out_valid<=0 until the shadow completes.
  - Sustained throughput: one vector per WORDS cycles (one per cycle when WORDS=1).
- The LCG advances only on fill steps; a stalled consumer never advances it.
- stop, any state except IDLE:
  - Next cycle: IDLE, out_valid=0, done=0; vec_count holds.
  - The LCG state is retained, so the stream continues on the next start without a reload.
  - stop has priority over a simultaneous handshake: that vector is not counted.
- start, seed_load while busy: ignored.
- num_vec=0: free-run until stop; vec_count wraps 2^CNT_W-1 -> 0; done never sets.
- Reset mid-run: immediate return to the reset values above; any vector in flight is lost.
- Stream order: identical to a software reference that performs WORDS LCG steps per vector, in order.

Optional Feature:
- Macro: LCG_STIM_CHECKSUM_EN.
- Defined:
  - Adds output port checksum[31:0].
  - Reset value 0; cleared on start.
  - On each handshake, XORs in every 32-bit word of the accepted vector. The partial top word is zero-extended.
  - Unaffected by stop.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Basic run: OUT_W=64, seed_load seed_in=0, start num_vec=1, out_ready=1 -> out_valid at T+3; out_vec=64'hD3DC167E_00003039; vec_count=1; done=1 the next cycle.
- Throughput: OUT_W=141 default seed, num_vec=200, out_ready=1 -> 200 vectors at one per 5 cycles, matching the software LCG model; done=1, vec_count=200.
- Backpressure: out_ready=0 for 20 cycles -> out_vec stable, LCG advances at most 5 steps (shadow fill); after release the stream matches the unstalled reference exactly.
- Stop: stop mid-run at vec_count=3, then start num_vec=2 -> IDLE next cycle, done=0; the next vectors continue the LCG sequence from where it stopped.
- Wrap: CNT_W=4, num_vec=0, 20 handshakes -> vec_count shows 4 after 20; done stays 0.
- Async reset: rst_n low while in PRESENT -> out_valid=0 and out_vec=0 immediately; after release with start, the first vector equals the SEED-derived vector.

Source files
------------

// File: rtl/lcg_stim_gen.sv
// lcg_stim_gen: deterministic pseudo-random vector source driven by a 32-bit LCG
// (state = state*0x41C64E6D + 0x3039). Each OUT_W-bit vector is built from
// consecutive LCG words, LSW first. The top partial word keeps the low bits of its step.
// Vectors are presented on a valid/ready handshake while the next one is prefetched
// into a shadow buffer.
// Optional feature: define LCG_STIM_CHECKSUM_EN to add a 32-bit XOR checksum output
// covering every accepted vector.
module lcg_stim_gen #(
  parameter int          OUT_W = 141,
  parameter logic [31:0] SEED  = 32'hF30AC820,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [31:0]      seed_in,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             stop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_vec,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_count
`ifdef LCG_STIM_CHECKSUM_EN
  ,
  output logic [31:0]      checksum
`endif
);

  localparam int          WORDS   = (OUT_W + 31) / 32;
  localparam int          IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [31:0] LCG_MUL = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC = 32'h00003039;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FILL    = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]       state_q;
  logic [31:0]      lcg_state;
  logic [31:0]      lcg_next;
  logic [OUT_W-1:0] shadow;
  logic [OUT_W-1:0] shadow_next;
  logic             shadow_full;
  logic [IDX_W-1:0] fill_idx;
  logic [CNT_W-1:0] num_lat;
  logic [CNT_W-1:0] count_next;
  logic             filling;
  logic             last_step;
  logic             handshake;
  logic             run_end;

  assign lcg_next   = lcg_state * LCG_MUL + LCG_INC;
  // The shadow is being filled during the initial FILL and in PRESENT until it is full.
  assign filling    = (state_q == S_FILL) || ((state_q == S_PRESENT) && !shadow_full);
  assign last_step  = filling && (fill_idx == IDX_W'(WORDS - 1));
  assign handshake  = out_valid && out_ready;
  assign count_next = vec_count + CNT_W'(1);
  assign run_end    = (num_lat != '0) && (count_next == num_lat);
  assign busy       = (state_q == S_FILL) || (state_q == S_PRESENT);

  // Splice the current LCG step into the shadow word selected by fill_idx.
  // The top slice is narrower than 32 bits when OUT_W is not a multiple of 32.
  for (genvar w = 0; w < WORDS; w++) begin : g_word
    localparam int LO = 32 * w;
    localparam int HI = ((32 * w + 31) < OUT_W) ? (32 * w + 31) : (OUT_W - 1);
    assign shadow_next[HI:LO] = (fill_idx == IDX_W'(w)) ? lcg_next[HI-LO:0] : shadow[HI:LO];
`ifdef LCG_STIM_CHECKSUM_EN
    logic [31:0] acc;
    if (w == 0) begin : g_first
      assign acc = 32'(out_vec[HI:LO]);
    end else begin : g_rest
      assign acc = g_word[w-1].acc ^ 32'(out_vec[HI:LO]);
    end
`endif
  end

  // Main sequencer: run control, LCG stepping, shadow prefetch and output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lcg_state   <= SEED;
      shadow      <= '0;
      shadow_full <= 1'b0;
      fill_idx    <= '0;
      num_lat     <= '0;
      out_vec     <= '0;
      out_valid   <= 1'b0;
      done        <= 1'b0;
      vec_count   <= '0;
    end else if (stop && (state_q != S_IDLE)) begin
      state_q     <= S_IDLE;
      out_valid   <= 1'b0;
      done        <= 1'b0;
      shadow_full <= 1'b0;
      fill_idx    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (seed_load) lcg_state <= seed_in;
          if (start) begin
            num_lat     <= num_vec;
            vec_count   <= '0;
            done        <= 1'b0;
            shadow_full <= 1'b0;
            fill_idx    <= '0;
            state_q     <= S_FILL;
          end
        end
        S_FILL: begin
          lcg_state <= lcg_next;
          shadow    <= shadow_next;
          if (last_step) begin
            out_vec   <= shadow_next;
            out_valid <= 1'b1;
            fill_idx  <= '0;
            state_q   <= S_PRESENT;
          end else begin
            fill_idx <= fill_idx + IDX_W'(1);
          end
        end
        S_PRESENT: begin
          if (filling) begin
            lcg_state <= lcg_next;
            shadow    <= shadow_next;
            if (last_step) begin
              shadow_full <= 1'b1;
              fill_idx    <= '0;
            end else begin
              fill_idx <= fill_idx + IDX_W'(1);
            end
          end
          if (handshake) begin
            vec_count <= count_next;
            if (run_end) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state_q   <= S_DONE;
            end else if (shadow_full) begin
              out_vec     <= shadow;
              shadow_full <= 1'b0;
            end else if (last_step) begin
              out_vec     <= shadow_next;
              shadow_full <= 1'b0;
            end else begin
              out_valid <= 1'b0;
            end
          end else if (!out_valid && last_step) begin
            out_vec     <= shadow_next;
            out_valid   <= 1'b1;
            shadow_full <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef LCG_STIM_CHECKSUM_EN
  // XOR-accumulate every accepted vector; a new run clears it, stop leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (stop && (state_q != S_IDLE)) begin
      checksum <= checksum;
    end else if (start && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
      checksum <= '0;
    end else if ((state_q == S_PRESENT) && handshake) begin
      checksum <= checksum ^ g_word[WORDS-1].acc;
    end
  end
`endif

endmodule

// File: tb/tb_lcg_stim_gen.sv
// tb_lcg_stim_gen: three configurations share one stimulus bus (64-bit, default
// 141-bit, and 32-bit with a 4-bit counter); each scenario checks the relevant one
// against a word-stream LCG reference model.
module tb_lcg_stim_gen;

  logic         clk;
  logic         rst_n;
  logic         seed_load;
  logic [31:0]  seed_in;
  logic         start;
  logic [15:0]  num_vec;
  logic         stop;
  logic         out_ready;

  logic         a_valid, a_busy, a_done;
  logic [63:0]  a_vec;
  logic [15:0]  a_count;
  logic         b_valid, b_busy, b_done;
  logic [140:0] b_vec;
  logic [15:0]  b_count;
  logic         c_valid, c_busy, c_done;
  logic [31:0]  c_vec;
  logic [3:0]   c_count;
`ifdef LCG_STIM_CHECKSUM_EN
  logic [31:0]  a_csum, b_csum, c_csum;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [31:0] mst;

  typedef struct {
    logic [31:0] seed;
    logic        same_cycle;
    logic [15:0] nvec;
    logic [63:0] exp_first;
  } basic_vec_t;

  basic_vec_t tbl [5];

  lcg_stim_gen #(.OUT_W(64), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in), .start(start),
    .num_vec(num_vec), .stop(stop), .out_valid(a_valid), .out_ready(out_ready),
    .out_vec(a_vec), .busy(a_busy), .done(a_done), .vec_count(a_count)
`ifdef LCG_STIM_CHECKSUM_EN
    , .checksum(a_csum)
`endif
  );

  lcg_stim_gen dut_b (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in), .start(start),
    .num_vec(num_vec), .stop(stop), .out_valid(b_valid), .out_ready(out_ready),
    .out_vec(b_vec), .busy(b_busy), .done(b_done), .vec_count(b_count)
`ifdef LCG_STIM_CHECKSUM_EN
    , .checksum(b_csum)
`endif
  );

  lcg_stim_gen #(.OUT_W(32), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in), .start(start),
    .num_vec(num_vec[3:0]), .stop(stop), .out_valid(c_valid), .out_ready(out_ready),
    .out_vec(c_vec), .busy(c_busy), .done(c_done), .vec_count(c_count)
`ifdef LCG_STIM_CHECKSUM_EN
    , .checksum(c_csum)
`endif
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] lcgStep(input logic [31:0] s);
    return s * 32'h41C64E6D + 32'h00003039;
  endfunction

  // Next reference vector of the given width: ceil(width/32) LCG steps, LSW first.
  task automatic modelNext(input int width, output logic [1023:0] v);
    logic [1023:0] mask;
    v = '0;
    for (int w = 0; w < (width + 31) / 32; w++) begin
      mst = lcgStep(mst);
      v[w*32 +: 32] = mst;
    end
    mask = ~({1024{1'b1}} << width);
    v = v & mask;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input logic sl, input logic [31:0] si, input logic st,
                               input logic [15:0] nv, input logic sp, input logic rdy);
    seed_load = sl;
    seed_in   = si;
    start     = st;
    num_vec   = nv;
    stop      = sp;
    out_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic stopPulse();
    applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [1023:0] v;
    logic [140:0]  held;
    logic [31:0]   seed;
    int            lat, acc, guard, gaps, first, last, c0, unstable;
    logic          rdy, stalled, wrapped;

    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b0);

    tbl[0] = '{32'h0, 1'b0, 16'd1, 64'hD3DC167E_00003039};
    tbl[1] = '{32'h0, 1'b1, 16'd2, 64'hD3DC167E_00003039};
    for (int i = 2; i < 5; i++) begin
      tbl[i].seed       = $urandom;
      tbl[i].same_cycle = 1'($urandom_range(0, 1));
      tbl[i].nvec       = 16'($urandom_range(1, 3));
      mst = tbl[i].seed;
      modelNext(64, v);
      tbl[i].exp_first = v[63:0];
    end

    $display("[TB] reset state");
    tick(); tick();
    checkOutput("rst_a_valid", a_valid, 0);
    checkOutput("rst_a_vec", a_vec, 0);
    checkOutput("rst_a_busy", a_busy, 0);
    checkOutput("rst_a_done", a_done, 0);
    checkOutput("rst_a_count", a_count, 0);
    checkOutput("rst_b_vec", b_vec, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] basic runs, OUT_W=64");
    for (int i = 0; i < 5; i++) begin
      mst = tbl[i].seed;
      modelNext(64, v);
      if (!tbl[i].same_cycle) begin
        applyStimulus(1'b1, tbl[i].seed, 1'b0, 16'h0, 1'b0, 1'b1);
        tick();
      end
      applyStimulus(tbl[i].same_cycle, tbl[i].seed, 1'b1, tbl[i].nvec, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b1);
      lat = 1;
      while (!a_valid && lat < 20) begin tick(); lat++; end
      checkOutput($sformatf("basic%0d_latency", i), lat, 3);
      checkOutput($sformatf("basic%0d_vec0", i), a_vec, tbl[i].exp_first);
      tick();
      for (int k = 1; k < int'(tbl[i].nvec); k++) begin
        guard = 0;
        while (!a_valid && guard < 20) begin tick(); guard++; end
        modelNext(64, v);
        checkOutput($sformatf("basic%0d_vec%0d", i, k), a_vec, v[63:0]);
        tick();
      end
      checkOutput($sformatf("basic%0d_done", i), a_done, 1);
      checkOutput($sformatf("basic%0d_count", i), a_count, tbl[i].nvec);
      checkOutput($sformatf("basic%0d_valid_low", i), a_valid, 0);
`ifdef LCG_STIM_CHECKSUM_EN
      if (i == 0) checkOutput("basic0_checksum", a_csum, tbl[0].exp_first[31:0] ^ tbl[0].exp_first[63:32]);
`endif
    end

    $display("[TB] async reset while presenting");
    stopPulse();
    applyStimulus(1'b0, 32'h0, 1'b1, 16'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    guard = 0;
    while (!b_valid && guard < 30) begin tick(); guard++; end
    checkOutput("ar_presenting", b_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", b_valid, 0);
    checkOutput("ar_vec", b_vec, 0);
    checkOutput("ar_busy", b_busy, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] throughput, OUT_W=141, 200 vectors from SEED");
    c0 = cyc;
    applyStimulus(1'b0, 32'h0, 1'b1, 16'd200, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    mst = 32'hF30AC820;
    acc = 0; gaps = 0; guard = 0; first = 0; last = 0;
    while (acc < 200 && guard < 3000) begin
      if (b_valid) begin
        modelNext(141, v);
        checkOutput($sformatf("tp_vec%0d", acc), b_vec, v[140:0]);
        if (acc == 0) first = cyc;
        else if (cyc - last != 5) gaps++;
        last = cyc;
        acc++;
      end
      tick();
      guard++;
    end
    checkOutput("tp_accepted", acc, 200);
    checkOutput("tp_first_latency", first - c0, 6);
    checkOutput("tp_interval_errors", gaps, 0);
    checkOutput("tp_done", b_done, 1);
    checkOutput("tp_count", b_count, 200);

    $display("[TB] backpressure with random ready and a 20-cycle stall");
    stopPulse();
    seed = $urandom;
    mst = seed;
    applyStimulus(1'b1, seed, 1'b1, 16'd30, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    acc = 0; guard = 0; stalled = 1'b0;
    while (acc < 30 && guard < 3000) begin
      if (acc == 5 && !stalled && b_valid) begin
        out_ready = 1'b0;
        held = b_vec;
        unstable = 0;
        repeat (20) begin
          tick();
          guard++;
          if (b_valid !== 1'b1 || b_vec !== held) unstable++;
        end
        checkOutput("bp_stall_stable", unstable, 0);
        stalled = 1'b1;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
        out_ready = rdy;
        if (b_valid && rdy) begin
          modelNext(141, v);
          checkOutput($sformatf("bp_vec%0d", acc), b_vec, v[140:0]);
          acc++;
        end
        tick();
        guard++;
      end
    end
    out_ready = 1'b0;
    checkOutput("bp_accepted", acc, 30);
    checkOutput("bp_stall_seen", stalled, 1);
    checkOutput("bp_done", b_done, 1);
    checkOutput("bp_count", b_count, 30);

    $display("[TB] stop mid-run and resume");
    stopPulse();
    seed = $urandom;
    mst = seed;
    applyStimulus(1'b1, seed, 1'b1, 16'd10, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    guard = 0;
    while (b_count != 16'd3 && guard < 500) begin
      if (b_valid) begin
        modelNext(141, v);
        checkOutput("st_vec_pre", b_vec, v[140:0]);
      end
      tick();
      guard++;
    end
    out_ready = 1'b0;
    checkOutput("st_reached3", b_count, 3);
    repeat (15) tick();
    checkOutput("st_presenting", b_valid, 1);
    stop = 1'b1;
    out_ready = 1'b1;
    tick();
    stop = 1'b0;
    out_ready = 1'b0;
    checkOutput("st_idle", b_busy, 0);
    checkOutput("st_valid", b_valid, 0);
    checkOutput("st_done", b_done, 0);
    checkOutput("st_count_held", b_count, 3);
    modelNext(141, v);
    modelNext(141, v);
    applyStimulus(1'b0, 32'h0, 1'b1, 16'd2, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    acc = 0; guard = 0;
    while (acc < 2 && guard < 100) begin
      if (b_valid) begin
        modelNext(141, v);
        checkOutput($sformatf("st_resume_vec%0d", acc), b_vec, v[140:0]);
        acc++;
      end
      tick();
      guard++;
    end
    checkOutput("st_resume_accepted", acc, 2);
    checkOutput("st_resume_done", b_done, 1);
    checkOutput("st_resume_count", b_count, 2);

    $display("[TB] free-run counter wrap, OUT_W=32, CNT_W=4");
    stopPulse();
    seed = $urandom;
    mst = seed;
    applyStimulus(1'b1, seed, 1'b1, 16'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    acc = 0; gaps = 0; guard = 0; last = 0; wrapped = 1'b0;
    while (acc < 20 && guard < 200) begin
      if (acc == 16 && !wrapped) begin
        checkOutput("wr_count_at16", c_count, 0);
        wrapped = 1'b1;
      end
      if (c_valid) begin
        modelNext(32, v);
        checkOutput($sformatf("wr_vec%0d", acc), c_vec, v[31:0]);
        if (acc > 0 && cyc - last != 1) gaps++;
        last = cyc;
        acc++;
      end
      tick();
      guard++;
    end
    checkOutput("wr_accepted", acc, 20);
    checkOutput("wr_interval_errors", gaps, 0);
    checkOutput("wr_count", c_count, 4);
    checkOutput("wr_done", c_done, 0);
    checkOutput("wr_busy", c_busy, 1);
    stopPulse();
    checkOutput("wr_stopped", c_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
